// File: rtl/pc_fetch_stage.sv
// pc_fetch_stage: program-counter register and IF/ID pipeline latch.
// Next PC is chosen from a jump, a branch, a held value or PC+4.
// A redirect to a misaligned target stops fetch in HALT until reset.
// Optional feature macro: FETCH_COUNT_EN adds the FetchCount output.
//
// Valid semantics: IFID_Valid=1 means IF/ID holds a real fetched
// instruction. IFID_Valid=0 means it holds a bubble (NOP_INSTR).
// The block has no backpressure. Stall is the only hold input.
// The FSM state is visible on Halted (1 = HALT, 0 = RUN).
module pc_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] PCAddResult,
  input  logic [31:0] Instruction,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  output logic [31:0] PCResult,
  output logic [31:0] IFID_PCPlus4,
  output logic [31:0] IFID_Instruction,
  output logic        IFID_Valid,
  output logic        Halted
`ifdef FETCH_COUNT_EN
  ,
  output logic [31:0] FetchCount
`endif
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;

  logic        redirect;
  logic [31:0] redirect_tgt;
  logic        misaligned;

  // Jump outranks branch. A target is misaligned if its low two bits are not zero.
  always_comb begin
    redirect     = Jump | BranchTaken;
    redirect_tgt = Jump ? JumpTarget : BranchTarget;
    misaligned   = redirect & (redirect_tgt[1:0] != 2'b00);
  end

  // State register for the FSM and the datapath flops.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q         <= ST_RUN;
      pc_q            <= RESET_PC;
      ifid_pc_plus4_q <= 32'h0000_0000;
      ifid_instr_q    <= NOP_INSTR;
      ifid_valid_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      ifid_pc_plus4_q <= ifid_pc_plus4_d;
      ifid_instr_q    <= ifid_instr_d;
      ifid_valid_q    <= ifid_valid_d;
    end
  end

  // Next-state logic. HALT is left only through reset.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_RUN && misaligned) state_d = ST_HALT;
  end

  // Next PC and IF/ID contents. A redirect loads a bubble, which squashes the wrong-path word.
  always_comb begin
    pc_d            = pc_q;
    ifid_pc_plus4_d = ifid_pc_plus4_q;
    ifid_instr_d    = ifid_instr_q;
    ifid_valid_d    = ifid_valid_q;
    if (state_q == ST_HALT) begin
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
    end else if (redirect) begin
      // A misaligned target is never loaded. The PC keeps its value.
      if (!misaligned) pc_d = redirect_tgt;
      ifid_pc_plus4_d = PCAddResult;
      ifid_instr_d    = NOP_INSTR;
      ifid_valid_d    = 1'b0;
    end else begin
      if (!Stall) pc_d = PCAddResult;
      if (Flush) begin
        ifid_pc_plus4_d = PCAddResult;
        ifid_instr_d    = NOP_INSTR;
        ifid_valid_d    = 1'b0;
      end else if (!Stall) begin
        ifid_pc_plus4_d = PCAddResult;
        ifid_instr_d    = Instruction;
        ifid_valid_d    = 1'b1;
      end
    end
  end

`ifdef FETCH_COUNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;

  // Count the edges that load a real instruction. The count wraps at 2^32.
  always_comb begin
    fetch_count_d = fetch_count_q;
    if (state_q == ST_RUN && !redirect && !Flush && !Stall)
      fetch_count_d = fetch_count_q + 32'd1;
  end

  // Fetch counter register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) fetch_count_q <= 32'h0000_0000;
    else        fetch_count_q <= fetch_count_d;
  end

  assign FetchCount = fetch_count_q;
`endif

  assign PCResult         = pc_q;
  assign IFID_PCPlus4     = ifid_pc_plus4_q;
  assign IFID_Instruction = ifid_instr_q;
  assign IFID_Valid       = ifid_valid_q;
  assign Halted           = (state_q == ST_HALT);

endmodule

// File: doc/pc_fetch_stage.md
Name: pc_fetch_stage

Overview:
- Program-counter register and IF/ID pipeline latch for the single-issue MIPS datapath.
- Holds the current PC and drives it to the PC adder and the instruction memory.
- Accepts PC+4 back from the adder and selects the next PC from sequential, branch or jump sources.
- Latches PC+4 and the fetched instruction into IF/ID, with stall, flush and a misaligned-target halt FSM.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word injected into IF/ID as a bubble (sll $0,$0,0).

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-low reset (0 = reset).
- PCAddResult  input  32  PC+4 from the PC adder (combinational from PCResult).
- Instruction  input  32  instruction memory read data for the current PCResult.
- Stall  input  1  hazard-unit stall: hold PC and IF/ID.
- Flush  input  1  load a bubble into IF/ID; PC advances normally.
- BranchTaken  input  1  redirect to BranchTarget.
- BranchTarget  input  32  branch destination address.
- Jump  input  1  redirect to JumpTarget.
- JumpTarget  input  32  jump destination address.
- PCResult  output  32  current PC.
- IFID_PCPlus4  output  32  latched PC+4.
- IFID_Instruction  output  32  latched instruction.
- IFID_Valid  output  1  1 = IF/ID holds a real instruction; 0 = bubble.
- Halted  output  1  1 = fetch stopped on a misaligned redirect target.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values, applied immediately when Reset=0:
  - PCResult=RESET_PC.
  - IFID_PCPlus4=0.
  - IFID_Instruction=NOP_INSTR.
  - IFID_Valid=0.
  - Halted=0.
  - FSM=RUN.
- Reset asserted mid-operation discards all state, including HALT.
- FSM states: RUN and HALT.
  - RUN -> HALT when a selected redirect target has bits [1:0] != 2'b00.
  - HALT exits only through reset.
- Next-PC priority in RUN, evaluated each rising edge:
  - Jump -> JumpTarget.
  - else BranchTaken -> BranchTarget.
  - else Stall -> hold PCResult.
  - else -> PCAddResult.
- Redirect overrides Stall; simultaneous Jump and BranchTaken: Jump wins.
- IF/ID update in RUN:
  - Redirect (Jump or BranchTaken): load bubble (Instruction=NOP_INSTR, Valid=0, PCPlus4=PCAddResult). The wrong-path instruction is squashed.
  - else Flush: load bubble. Flush with Stall: Flush wins in IF/ID, but the PC still holds.
  - else Stall: hold all IF/ID fields.
  - else: IFID_PCPlus4<=PCAddResult, IFID_Instruction<=Instruction, IFID_Valid<=1.
- Misaligned redirect: the PC does not load the bad target; the PC holds its value.
  - IF/ID loads a bubble.
  - Halted goes to 1 on the same edge.
- HALT state:
  - PC frozen.
  - IF/ID forced to bubble each cycle.
  - All inputs ignored.
- Latency: one cycle from redirect to the new PCResult; the new PC's instruction appears in IF/ID on the following edge.
- Arithmetic: no adder inside the block; PC+4 comes from PCAddResult. 32-bit wrap-around (32'hFFFF_FFFC+4=0) is accepted without error.

Optional Feature:
- Macro FETCH_COUNT_EN.
- When defined:
  - Adds output FetchCount [31:0], reset to 0.
  - Increments on every edge where IF/ID loads a valid instruction.
  - Wraps from 32'hFFFF_FFFF to 0.
  - Holds on stall, bubble and HALT.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset=0 then released, no stall/redirect, Instruction=PC-indexed pattern -> PCResult 0,4,8,12 on successive edges; IFID_Valid=1 from the 2nd edge; IFID_PCPlus4=4,8,12.
- PC=8, Stall=1 for 2 cycles -> PCResult stays 8 and IF/ID unchanged for 2 edges; resumes at 12 after Stall drops.
- PC=16, BranchTaken=1, BranchTarget=32'h40, Stall=1 together -> next PCResult=0x40; IFID_Valid=0 and IFID_Instruction=NOP_INSTR.
- Jump=1 with JumpTarget=0x100 and BranchTaken=1 with BranchTarget=0x200 on the same edge -> PCResult=0x100.
- BranchTaken=1, BranchTarget=0x42 -> Halted=1, PC holds, IFID_Valid=0 thereafter despite further inputs; Reset=0 pulse between clock edges -> immediate PCResult=RESET_PC, Halted=0.
- FETCH_COUNT_EN defined: 5 valid fetches, 1 flush, 2 stall cycles -> FetchCount=5.
